// File: rtl/ro_slot_capture_pkg.sv
// Shared definitions for the readout-bus slot capture path.
// The ctz decoder is kept here so a transmit-side checker can reuse it.
package ro_slot_capture_pkg;

  localparam int N_CH_DEFAULT = 19;
  localparam int CH_W_DEFAULT = 5;
  localparam int ENTRY_W_DEFAULT = CH_W_DEFAULT + 1;

  typedef struct packed {
    logic [CH_W_DEFAULT-1:0] ch;
    logic                    pol;
  } entry_t;

  // Index of the lowest set bit; a zero input returns 0.
  function automatic int ctz(input logic [31:0] v);
    ctz = 0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) ctz = i;
    end
  endfunction

endpackage

// File: rtl/ro_slot_capture_if.sv
// Valid/ready output stream of captured readout-bus events.
interface ro_slot_capture_if #(
  parameter int CH_W = 5
);
  logic            out_valid;
  logic            out_ready;
  logic [CH_W-1:0] out_ch;
  logic            out_pol;

  modport master (output out_valid, output out_ch, output out_pol, input out_ready);
  modport slave  (input out_valid, input out_ch, input out_pol, output out_ready);
endinterface

// File: rtl/ro_evt_fifo.sv
// Synchronous event FIFO with valid/ready pop and a sticky overflow flag.
// An empty FIFO presents zero data; a full FIFO still accepts a push when popped.
module ro_evt_fifo #(
  parameter int W     = 6,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wr_data,
  input  logic         rd_ready,
  input  logic         clr_ovf,
  output logic         rd_valid,
  output logic [W-1:0] rd_data,
  output logic         ovf
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   occ;
  logic          full;
  logic          pop;
  logic          wr_en;

  assign full     = (occ == (AW+1)'(DEPTH));
  assign rd_valid = (occ != '0);
  assign pop      = rd_valid & rd_ready;
  assign wr_en    = push & (~full | pop);
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      // a drop in the same cycle as a clear leaves the flag set
      if (push & ~wr_en)  ovf <= 1'b1;
      else if (clr_ovf)   ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/ro_slot_capture.sv
// Readout-bus receiver: regenerates the slot schedule, attributes each slot
// to the channel whose Gray bit toggled, and buffers event-carrying slots.
module ro_slot_capture
  import ro_slot_capture_pkg::*;
#(
  parameter int N_CH  = N_CH_DEFAULT,
  parameter int CH_W  = CH_W_DEFAULT,
  parameter int DEPTH = 8
) (
  input  logic                  clk_master,
  input  logic                  rstb,
  input  logic                  en,
  input  logic                  in_eve,
  input  logic                  in_pol_eve,
  input  logic                  clr_ovf,
  ro_slot_capture_if.master     out_if,
  output logic                  frame_start,
  output logic                  ovf
);
  logic [N_CH-1:0] cnt;
  logic [CH_W-1:0] slot_ch;
  logic            push;
  logic [CH_W:0]   wr_data;
  logic [CH_W:0]   rd_data;

  // slot c is owned by the Gray bit that toggled on the increment to c
  assign slot_ch = CH_W'(ctz(32'(cnt)));
  assign push    = en & in_eve & (cnt != '0);
  assign wr_data = {slot_ch, in_pol_eve};

  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      cnt         <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= en & (&cnt);
      if (en) cnt <= cnt + 1'b1;
    end
  end

  ro_evt_fifo #(
    .W     (CH_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk_master),
    .rst_n    (rstb),
    .push     (push),
    .wr_data  (wr_data),
    .rd_ready (out_if.out_ready),
    .clr_ovf  (clr_ovf),
    .rd_valid (out_if.out_valid),
    .rd_data  (rd_data),
    .ovf      (ovf)
  );

  assign out_if.out_ch  = rd_data[CH_W:1];
  assign out_if.out_pol = rd_data[0];

endmodule

// File: tb/tb_ro_slot_capture.sv
// Scoreboard bench for ro_slot_capture: a default instance (N_CH=19) under
// directed and random traffic, plus a small N_CH=4 instance for frame wrap.
module tb_ro_slot_capture;
  import ro_slot_capture_pkg::*;

  localparam int N     = 19;
  localparam int N4    = 4;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstb = 1'b0, en = 1'b0, in_eve = 1'b0, in_pol_eve = 1'b0, clr_ovf = 1'b0;
  logic frame_start, ovf;
  ro_slot_capture_if #(.CH_W(5)) bus ();

  logic rst4_n = 1'b0, en4 = 1'b0, eve4 = 1'b1, pol4 = 1'b0, clr4 = 1'b0;
  logic frame4, ovf4;
  ro_slot_capture_if #(.CH_W(5)) bus4 ();

  ro_slot_capture dut (
    .clk_master (clk), .rstb (rstb), .en (en), .in_eve (in_eve),
    .in_pol_eve (in_pol_eve), .clr_ovf (clr_ovf), .out_if (bus),
    .frame_start (frame_start), .ovf (ovf)
  );

  ro_slot_capture #(.N_CH(N4)) dut4 (
    .clk_master (clk), .rstb (rst4_n), .en (en4), .in_eve (eve4),
    .in_pol_eve (pol4), .clr_ovf (clr4), .out_if (bus4),
    .frame_start (frame4), .ovf (ovf4)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ref_ctz(input int c);
    int k = 0;
    while ((c % 2) == 0 && k < 32) begin
      c = c / 2;
      k++;
    end
    return k;
  endfunction

  // ---------------- reference model, default instance ----------------
  entry_t exp_q[$];
  int     m_occ = 0;
  int     m_cnt = 0;
  bit     exp_ovf = 1'b0;
  bit     exp_frame = 1'b0;

  always @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      exp_q.delete();
      m_occ = 0; m_cnt = 0; exp_ovf = 1'b0; exp_frame = 1'b0;
    end else begin
      bit     pop, drop;
      entry_t e;
      pop  = bus.out_ready && (m_occ > 0);
      drop = 1'b0;
      exp_frame = 1'b0;
      if (en) begin
        if (in_eve && m_cnt != 0) begin
          if (m_occ < DEPTH || pop) begin
            e.ch  = 5'(ref_ctz(m_cnt));
            e.pol = in_pol_eve;
            exp_q.push_back(e);
            m_occ++;
          end else drop = 1'b1;
        end
        exp_frame = (m_cnt == (1 << N) - 1);
        m_cnt = (m_cnt + 1) % (1 << N);
      end
      if (pop) m_occ--;
      if (drop) exp_ovf = 1'b1;
      else if (clr_ovf) exp_ovf = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rstb) begin
      check("out_valid", bus.out_valid, 32'(m_occ > 0));
      check("occupancy", 32'(dut.u_fifo.occ), m_occ);
      check("ovf", ovf, exp_ovf);
      check("frame_start", frame_start, exp_frame);
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_entry", 1, 0);
        end else begin
          check("head_ch", bus.out_ch, exp_q[0].ch);
          check("head_pol", bus.out_pol, exp_q[0].pol);
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end else begin
        check("empty_ch", bus.out_ch, 0);
        check("empty_pol", bus.out_pol, 0);
      end
    end
  end

  // ---------------- reference model, N_CH=4 instance ----------------
  entry_t q4[$];
  int     occ4 = 0, cnt4 = 0, cyc = 0, last_frame4 = -1;
  bit     ef4 = 1'b0;

  always @(posedge clk) cyc++;

  always @(posedge clk or negedge rst4_n) begin
    if (!rst4_n) begin
      q4.delete();
      occ4 = 0; cnt4 = 0; ef4 = 1'b0;
    end else begin
      bit     pop;
      entry_t e;
      pop = bus4.out_ready && (occ4 > 0);
      ef4 = 1'b0;
      if (en4) begin
        if (eve4 && cnt4 != 0 && (occ4 < DEPTH || pop)) begin
          e.ch  = 5'(ref_ctz(cnt4));
          e.pol = pol4;
          q4.push_back(e);
          occ4++;
        end
        ef4  = (cnt4 == (1 << N4) - 1);
        cnt4 = (cnt4 + 1) % (1 << N4);
      end
      if (pop) occ4--;
    end
  end

  always @(negedge clk) begin
    if (rst4_n) begin
      check("n4_frame_start", frame4, ef4);
      check("n4_out_valid", bus4.out_valid, 32'(occ4 > 0));
      check("n4_ovf", ovf4, 0);
      if (frame4) begin
        if (last_frame4 >= 0) check("n4_frame_period", cyc - last_frame4, 16);
        last_frame4 = cyc;
      end
      if (bus4.out_valid && q4.size() != 0) begin
        check("n4_head_ch", bus4.out_ch, q4[0].ch);
        check("n4_head_pol", bus4.out_pol, q4[0].pol);
        if (bus4.out_ready) void'(q4.pop_front());
      end else if (bus4.out_valid) begin
        check("n4_unexpected_entry", 1, 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
    pol4 = 1'($urandom);
  endtask

  task automatic do_reset();
    step();
    rstb = 1'b0; en = 1'b0; in_eve = 1'b0; in_pol_eve = 1'b0; clr_ovf = 1'b0;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_cnt", 32'(dut.cnt), 0);
    check("rst_ovf", ovf, 0);
    check("rst_frame_start", frame_start, 0);
    check("rst_out_ch", bus.out_ch, 0);
    step();
    rstb = 1'b1;
  endtask

  int c_list [4] = '{4, 12, 8, 16};
  bit p_list [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  int rp;

  initial begin
    bus.out_ready  = 1'b1;
    bus4.out_ready = 1'b1;
    step();
    do_reset();
    rst4_n = 1'b1;
    en4    = 1'b1;

    // idle bus: no pushes
    for (int i = 0; i < 64; i++) begin
      step(); en = 1'b1; in_eve = 1'b0; in_pol_eve = 1'b0;
    end

    // single event at c=5
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(); en = 1'b1;
      in_eve = (m_cnt == 5); in_pol_eve = (m_cnt == 5);
    end

    // events at chosen slots
    do_reset();
    for (int i = 0; i < 24; i++) begin
      step(); en = 1'b1; in_eve = 1'b0; in_pol_eve = 1'b0;
      for (int j = 0; j < 4; j++) begin
        if (m_cnt == c_list[j]) begin
          in_eve = 1'b1; in_pol_eve = p_list[j];
        end
      end
    end

    // fill to overflow, clear, then push+pop while full
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(); en = 1'b1; in_eve = 1'b1; in_pol_eve = 1'($urandom); bus.out_ready = 1'b0;
    end
    step(); in_eve = 1'b0; clr_ovf = 1'b1;
    step(); clr_ovf = 1'b0;
    step(); check("full_before_pushpop", m_occ, DEPTH);
    for (int i = 0; i < 4; i++) begin
      step(); in_eve = 1'b1; in_pol_eve = 1'($urandom); bus.out_ready = 1'b1;
    end
    for (int i = 0; i < 12; i++) begin
      step(); in_eve = 1'b0;
    end

    // randomized traffic
    for (int blk = 0; blk < 15; blk++) begin
      rp = (blk % 3 == 0) ? 20 : ((blk % 3 == 1) ? 55 : 90);
      for (int i = 0; i < 100; i++) begin
        step();
        en            = ($urandom_range(0, 7) != 0);
        in_eve        = 1'($urandom);
        in_pol_eve    = 1'($urandom);
        bus.out_ready = ($urandom_range(0, 99) < rp);
        clr_ovf       = ($urandom_range(0, 15) == 0);
      end
    end
    clr_ovf = 1'b0;

    // reset with 5 entries buffered, then restart from c=1
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(); en = 1'b1; in_eve = 1'b1; in_pol_eve = 1'($urandom); bus.out_ready = 1'b0;
    end
    step(); in_eve = 1'b0;
    step(); check("buffered_before_reset", m_occ, 5);
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(); en = 1'b1; in_eve = 1'b1; in_pol_eve = 1'($urandom); bus.out_ready = 1'b1;
    end

    // drain
    for (int i = 0; i < 12; i++) begin
      step(); en = 1'b0; in_eve = 1'b0; bus.out_ready = 1'b1;
    end
    check("scoreboard_drained", exp_q.size(), 0);
    check("n4_frames_seen", 32'(last_frame4 >= 0), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
